// File: rtl/memory_stage.sv
// MEM stage of the RV32I pipeline: byte-lane data memory, load extension and MEM/WB register.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (suppresses misaligned accesses and flags them).
module memory_stage #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        regwriteM,
    input  logic        memrwM,
    input  logic [1:0]  wbselM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  rdM,
    input  logic [31:0] ALUresM,
    input  logic [31:0] data_writeM,
    input  logic [31:0] pc4M,
    output logic        regwriteW,
    output logic [4:0]  rdW,
    output logic [31:0] resultW,
    output logic        misalignW
);

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] idx_s;
    logic [31:0]       rd_word_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic              misalign_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic [31:0]       load_s;
    logic              unused_addr_s;

    logic        regwrite_d, regwrite_q;
    logic [4:0]  rd_d, rd_q;
    logic [1:0]  wbsel_d, wbsel_q;
    logic [31:0] alu_d, alu_q;
    logic [31:0] load_d, load_q;
    logic [31:0] pc4_d, pc4_q;
    logic        misalign_d, misalign_q;

    // Upper address bits are deliberately ignored so the address space wraps.
    assign unused_addr_s = ^ALUresM[31:ADDR_W+2];

    // Address decode, lane extraction and misalignment detection.
    always_comb begin
        idx_s     = ALUresM[ADDR_W+1:2];
        rd_word_s = mem_q[idx_s];
        case (ALUresM[1:0])
            2'b00:   byte_s = rd_word_s[7:0];
            2'b01:   byte_s = rd_word_s[15:8];
            2'b10:   byte_s = rd_word_s[23:16];
            2'b11:   byte_s = rd_word_s[31:24];
            default: byte_s = 8'd0;
        endcase
        if (ALUresM[1]) begin
            half_s = rd_word_s[31:16];
        end else begin
            half_s = rd_word_s[15:0];
        end
`ifdef MEM_MISALIGN_CHECK_EN
        if (memrwM || (wbselM == 2'b00)) begin
            misalign_s = (((funct3M == 3'b001) || (funct3M == 3'b101)) && ALUresM[0])
                       || ((funct3M == 3'b010) && (ALUresM[1:0] != 2'b00));
        end else begin
            misalign_s = 1'b0;
        end
`else
        misalign_s = 1'b0;
`endif
    end

    // Store byte enables and lane-replicated store data.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = data_writeM;
        case (funct3M)
            3'b000:  wdata_s = {4{data_writeM[7:0]}};
            3'b001:  wdata_s = {2{data_writeM[15:0]}};
            default: wdata_s = data_writeM;
        endcase
        if (memrwM && !misalign_s) begin
            case (funct3M)
                3'b000:  be_s = 4'b0001 << ALUresM[1:0];
                3'b001:  be_s = ALUresM[1] ? 4'b1100 : 4'b0011;
                3'b010:  be_s = 4'b1111;
                default: be_s = 4'b0000;
            endcase
        end else begin
            be_s = 4'b0000;
        end
    end

    // Data memory write; the array is never reset, and a write is dropped while rst_n is low.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Load sign/zero extension.
    always_comb begin
        load_s = 32'd0;
        if (misalign_s) begin
            load_s = 32'd0;
        end else begin
            case (funct3M)
                3'b000:  load_s = {{24{byte_s[7]}}, byte_s};
                3'b001:  load_s = {{16{half_s[15]}}, half_s};
                3'b010:  load_s = rd_word_s;
                3'b100:  load_s = {24'd0, byte_s};
                3'b101:  load_s = {16'd0, half_s};
                default: load_s = 32'd0;
            endcase
        end
    end

    // MEM/WB next-state values; writes to x0 are squashed here.
    always_comb begin
        regwrite_d = regwriteM && (rdM != 5'd0);
        rd_d       = rdM;
        wbsel_d    = wbselM;
        alu_d      = ALUresM;
        load_d     = load_s;
        pc4_d      = pc4M;
        misalign_d = misalign_s;
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            wbsel_q    <= 2'b00;
            alu_q      <= 32'd0;
            load_q     <= 32'd0;
            pc4_q      <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wbsel_q    <= wbsel_d;
            alu_q      <= alu_d;
            load_q     <= load_d;
            pc4_q      <= pc4_d;
            misalign_q <= misalign_d;
        end
    end

    // Writeback mux.
    always_comb begin
        case (wbsel_q)
            2'b00:   resultW = load_q;
            2'b01:   resultW = alu_q;
            2'b10:   resultW = pc4_q;
            2'b11:   resultW = 32'd0;
            default: resultW = 32'd0;
        endcase
    end

    assign regwriteW = regwrite_q;
    assign rdW       = rd_q;
    assign misalignW = misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus pushes expected W-stage results, a monitor pops and compares.
module tb_memory_stage;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        regwriteM;
    logic        memrwM;
    logic [1:0]  wbselM;
    logic [2:0]  funct3M;
    logic [4:0]  rdM;
    logic [31:0] ALUresM;
    logic [31:0] data_writeM;
    logic [31:0] pc4M;
    logic        regwriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    logic        misalignW;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        mis;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic  chk_m;
    logic  chk_w;
    int    checks;
    int    errors;

    memory_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .regwriteM   (regwriteM),
        .memrwM      (memrwM),
        .wbselM      (wbselM),
        .funct3M     (funct3M),
        .rdM         (rdM),
        .ALUresM     (ALUresM),
        .data_writeM (data_writeM),
        .pc4M        (pc4M),
        .regwriteW   (regwriteW),
        .rdW         (rdW),
        .resultW     (resultW),
        .misalignW   (misalignW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Marks which W cycles carry an instruction that has an expectation queued.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) chk_w <= 1'b0;
        else        chk_w <= chk_m;
    end

    // Monitor: compare W outputs against the scoreboard head.
    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (chk_w) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: output present with no expectation");
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (resultW !== e.res) begin
                    errors++;
                    $display("FAIL %s result: got %h expected %h", n, resultW, e.res);
                end
                checks++;
                if (regwriteW !== e.rw) begin
                    errors++;
                    $display("FAIL %s regwrite: got %b expected %b", n, regwriteW, e.rw);
                end
                checks++;
                if (rdW !== e.rd) begin
                    errors++;
                    $display("FAIL %s rd: got %0d expected %0d", n, rdW, e.rd);
                end
                checks++;
                if (misalignW !== e.mis) begin
                    errors++;
                    $display("FAIL %s misalign: got %b expected %b", n, misalignW, e.mis);
                end
            end
        end
    end

    task automatic drive(input logic rw, input logic mrw, input logic [1:0] wb, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc4);
        regwriteM   = rw;
        memrwM      = mrw;
        wbselM      = wb;
        funct3M     = f3;
        rdM         = rd;
        ALUresM     = alu;
        data_writeM = wd;
        pc4M        = pc4;
    endtask

    task automatic issue(input string name, input logic rw, input logic mrw, input logic [1:0] wb,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [31:0] e_res, input logic e_rw, input logic e_mis);
        exp_t e;
        @(negedge clk);
        drive(rw, mrw, wb, f3, rd, alu, wd, pc4);
        e.rw  = e_rw;
        e.rd  = rd;
        e.res = e_res;
        e.mis = e_mis;
        exp_q.push_back(e);
        name_q.push_back(name);
        chk_m = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b01, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
        chk_m = 1'b0;
    endtask

    task automatic check_direct(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        chk_m  = 1'b0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 2'b01, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);

        // Reset with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, $urandom_range(0, 1) == 1, 2'($urandom), 3'($urandom), 5'($urandom),
                  $urandom, $urandom, $urandom);
        end
        @(negedge clk);
        check_direct("reset_regwriteW", {31'd0, regwriteW}, 32'd0);
        check_direct("reset_rdW", {27'd0, rdW}, 32'd0);
        check_direct("reset_resultW", resultW, 32'd0);
        check_direct("reset_misalignW", {31'd0, misalignW}, 32'd0);
        drive(1'b0, 1'b0, 2'b01, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;

        //     name          rw    mrw   wb     f3      rd     alu          wd            pc4     exp_res       e_rw  e_mis
        issue("sw_10",       1'b0, 1'b1, 2'b01, 3'b010, 5'd0,  32'h10,      32'hDEADBEEF, 32'd0,  32'h10,       1'b0, 1'b0);
        issue("lw_10",       1'b1, 1'b0, 2'b00, 3'b010, 5'd5,  32'h10,      32'd0,        32'd0,  32'hDEADBEEF, 1'b1, 1'b0);
        issue("sw_20",       1'b0, 1'b1, 2'b01, 3'b010, 5'd0,  32'h20,      32'h11223344, 32'd0,  32'h20,       1'b0, 1'b0);
        issue("sb_21",       1'b0, 1'b1, 2'b01, 3'b000, 5'd0,  32'h21,      32'hAAAAAA80, 32'd0,  32'h21,       1'b0, 1'b0);
        issue("lb_21",       1'b1, 1'b0, 2'b00, 3'b000, 5'd6,  32'h21,      32'd0,        32'd0,  32'hFFFFFF80, 1'b1, 1'b0);
        issue("lbu_21",      1'b1, 1'b0, 2'b00, 3'b100, 5'd7,  32'h21,      32'd0,        32'd0,  32'h00000080, 1'b1, 1'b0);
        issue("lw_20",       1'b1, 1'b0, 2'b00, 3'b010, 5'd8,  32'h20,      32'd0,        32'd0,  32'h11228044, 1'b1, 1'b0);
        issue("sw_30",       1'b0, 1'b1, 2'b01, 3'b010, 5'd0,  32'h30,      32'h00000000, 32'd0,  32'h30,       1'b0, 1'b0);
        issue("sh_32",       1'b0, 1'b1, 2'b01, 3'b001, 5'd0,  32'h32,      32'hBBBB8001, 32'd0,  32'h32,       1'b0, 1'b0);
        issue("lh_32",       1'b1, 1'b0, 2'b00, 3'b001, 5'd9,  32'h32,      32'd0,        32'd0,  32'hFFFF8001, 1'b1, 1'b0);
        issue("lhu_32",      1'b1, 1'b0, 2'b00, 3'b101, 5'd10, 32'h32,      32'd0,        32'd0,  32'h00008001, 1'b1, 1'b0);
        issue("lw_30",       1'b1, 1'b0, 2'b00, 3'b010, 5'd11, 32'h30,      32'd0,        32'd0,  32'h80010000, 1'b1, 1'b0);
        issue("alu_x0",      1'b1, 1'b0, 2'b01, 3'b000, 5'd0,  32'h1234,    32'd0,        32'd0,  32'h1234,     1'b0, 1'b0);
        issue("pc4_sel",     1'b1, 1'b0, 2'b10, 3'b000, 5'd3,  32'h99,      32'd0,        32'h44, 32'h44,       1'b1, 1'b0);
        issue("zero_sel",    1'b1, 1'b0, 2'b11, 3'b000, 5'd4,  32'h99,      32'd0,        32'h44, 32'h0,        1'b1, 1'b0);
        issue("lw_wrap",     1'b1, 1'b0, 2'b00, 3'b010, 5'd12, 32'h1010,    32'd0,        32'd0,  32'hDEADBEEF, 1'b1, 1'b0);
        issue("ld_bad_f3",   1'b1, 1'b0, 2'b00, 3'b011, 5'd13, 32'h10,      32'd0,        32'd0,  32'h0,        1'b1, 1'b0);
        issue("st_bad_f3",   1'b0, 1'b1, 2'b01, 3'b011, 5'd0,  32'h20,      32'hFFFFFFFF, 32'd0,  32'h20,       1'b0, 1'b0);
        issue("lw_20_again", 1'b1, 1'b0, 2'b00, 3'b010, 5'd14, 32'h20,      32'd0,        32'd0,  32'h11228044, 1'b1, 1'b0);
        issue("sw_13",       1'b0, 1'b1, 2'b01, 3'b010, 5'd0,  32'h13,      32'h55555555, 32'd0,  32'h13,       1'b0, MIS_EN);
        issue("lw_10_after", 1'b1, 1'b0, 2'b00, 3'b010, 5'd15, 32'h10,      32'd0,        32'd0,
              MIS_EN ? 32'hDEADBEEF : 32'h55555555, 1'b1, 1'b0);
        issue("lh_21",       1'b1, 1'b0, 2'b00, 3'b001, 5'd16, 32'h21,      32'd0,        32'd0,
              MIS_EN ? 32'h0 : 32'hFFFF8044, 1'b1, MIS_EN);
        issue("sw_40",       1'b0, 1'b1, 2'b01, 3'b010, 5'd0,  32'h40,      32'h01020304, 32'd0,  32'h40,       1'b0, 1'b0);
        idle();
        idle();

        // Store issued while reset is asserted at the edge must not write.
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 2'b01, 3'b010, 5'd0, 32'h40, 32'hCAFEF00D, 32'd0);
        @(negedge clk);
        check_direct("midreset_resultW", resultW, 32'd0);
        drive(1'b0, 1'b0, 2'b01, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        issue("lw_40_kept",  1'b1, 1'b0, 2'b00, 3'b010, 5'd17, 32'h40,      32'd0,        32'd0,  32'h01020304, 1'b1, 1'b0);
        issue("lw_10_kept",  1'b1, 1'b0, 2'b00, 3'b010, 5'd18, 32'h10,      32'd0,        32'd0,
              MIS_EN ? 32'hDEADBEEF : 32'h55555555, 1'b1, 1'b0);
        idle();

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
